ntt_pointwise_mult_seq: RTL and testbench

- Sequential, memory-facing pointwise multiplier: C[i] = (A[i]*B[i]) mod q for i = 0..N-1.
- Streams one coefficient pair per cycle from the A/B coefficient RAMs, reduces through a single mod_mult instance, and writes each result to the C RAM.
- Area-lean counterpart to the fully parallel flat-bus multiplier. Sits between the polynomial RAM bank and the NTT/INTT controller, which pulses start and waits for done.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/mod_mult.sv | 73 +++++++
 rtl/ntt_pointwise_mult_seq.sv | 156 +++++++++++++++
 tb/tb_ntt_pointwise_mult_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared FSM state, reduction selectors and default modulus for the NTT datapath
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int RED_SIMPLE     = 0;
    localparam int RED_BARRETT    = 1;
    localparam int RED_MONTGOMERY = 2;

    localparam longint unsigned DEFAULT_Q = 64'd8380417;

endpackage

// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - combinational (a*b) mod Q with simple, Barrett or Montgomery reduction
module mod_mult
    import ntt_pkg::*;
#(
    parameter int              WIDTH          = 32,
    parameter longint unsigned Q              = DEFAULT_Q,
    parameter int              REDUCTION_TYPE = RED_SIMPLE
)(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    localparam int            PW  = 2 * WIDTH;
    localparam int            XW  = 4 * WIDTH;
    localparam logic [XW-1:0] Q_X = XW'(Q);

    logic [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    // -Q^-1 mod 2^WIDTH by Newton iteration; Q must be odd for Montgomery.
    function automatic logic [WIDTH-1:0] neg_q_inv(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] inv;
        inv = q;
        for (int i = 0; i < 6; i++) begin
            inv = inv * (WIDTH'(2) - q * inv);
        end
        return '0 - inv;
    endfunction

    // REDC: t * 2^-WIDTH mod q for t < q * 2^WIDTH, fully reduced.
    function automatic logic [WIDTH-1:0] redc(input logic [PW-1:0] t,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] q_ninv);
        logic [WIDTH-1:0] m;
        logic [PW:0]      u;
        m = t[WIDTH-1:0] * q_ninv;
        u = ({1'b0, t} + (PW+1)'(m) * (PW+1)'(q)) >> WIDTH;
        if (u >= (PW+1)'(q)) begin
            u = u - (PW+1)'(q);
        end
        return WIDTH'(u);
    endfunction

    generate
        if (REDUCTION_TYPE == RED_BARRETT) begin : g_barrett
            localparam int            K  = $clog2(Q);
            localparam logic [XW-1:0] MU = (XW'(1) << (2 * K)) / Q_X;
            logic [XW-1:0] est;
            logic [XW-1:0] rem;
            // Quotient estimate is at most one low, so a single correction suffices.
            always_comb begin
                est = (XW'(prod) * MU) >> (2 * K);
                rem = XW'(prod) - est * Q_X;
                if (rem >= Q_X) begin
                    rem = rem - Q_X;
                end
            end
            assign result = WIDTH'(rem);
        end else if (REDUCTION_TYPE == RED_MONTGOMERY) begin : g_montgomery
            localparam logic [WIDTH-1:0] Q_W    = WIDTH'(Q);
            localparam logic [WIDTH-1:0] Q_NINV = neg_q_inv(Q_W);
            localparam logic [WIDTH-1:0] R2     = WIDTH'((XW'(1) << PW) % Q_X);
            logic [WIDTH-1:0] mont_ab;
            // Second REDC against R^2 cancels the R^-1 so callers see plain a*b mod Q.
            assign mont_ab = redc(prod, Q_W, Q_NINV);
            assign result  = redc(PW'(mont_ab) * PW'(R2), Q_W, Q_NINV);
        end else begin : g_simple
            assign result = WIDTH'(XW'(prod) % Q_X);
        end
    endgenerate

endmodule

// File: rtl/ntt_pointwise_mult_seq.sv
// rtl/ntt_pointwise_mult_seq.sv - RAM-streaming pointwise C[i]=A[i]*B[i] mod Q (NTT_PWM_EXTRA_PIPE_EN adds an input stage)
module ntt_pointwise_mult_seq
    import ntt_pkg::*;
#(
    parameter int              N              = 256,
    parameter int              WIDTH          = 32,
    parameter longint unsigned Q              = DEFAULT_Q,
    parameter int              REDUCTION_TYPE = RED_SIMPLE,
    localparam int             ADDR_W         = $clog2(N)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  a_rdata,
    input  logic [WIDTH-1:0]  b_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic              rd_vld;
    logic              mm_vld;
    logic [WIDTH-1:0]  mm_a;
    logic [WIDTH-1:0]  mm_b;
    logic [WIDTH-1:0]  mm_res;
    logic              last_write;

`ifdef NTT_PWM_EXTRA_PIPE_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             pipe_vld;

    // Extra register stage between the RAM outputs and the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            pipe_vld <= rd_vld;
            if (rd_vld) begin
                a_q <= a_rdata;
                b_q <= b_rdata;
            end
        end
    end

    assign mm_a   = a_q;
    assign mm_b   = b_q;
    assign mm_vld = pipe_vld;
`else
    assign mm_a   = a_rdata;
    assign mm_b   = b_rdata;
    assign mm_vld = rd_vld;
`endif

    mod_mult #(
        .WIDTH          (WIDTH),
        .Q              (Q),
        .REDUCTION_TYPE (REDUCTION_TYPE)
    ) u_mod_mult (
        .a      (mm_a),
        .b      (mm_b),
        .result (mm_res)
    );

    assign rd_addr    = rd_cnt;
    assign last_write = wr_en && (wr_addr == LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status strobes; start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (rd_cnt == LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_write) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read address counter; parks at 0 once the last read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (rd_en) begin
            rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + ADDR_W'(1);
        end
    end

    // RAM read data is valid the cycle after each read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
        end
    end

    // Register the reduced product and its address; wr_data holds between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
        end else begin
            wr_en   <= mm_vld;
            wr_addr <= mm_vld ? wr_cnt : '0;
            if (mm_vld) begin
                wr_data <= mm_res;
                wr_cnt  <= (wr_cnt == LAST) ? '0 : wr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ntt_pointwise_mult_seq.sv
// tb/tb_ntt_pointwise_mult_seq.sv - scoreboard bench for ntt_pointwise_mult_seq
module tb_ntt_pointwise_mult_seq;

    localparam int              W  = 32;
    localparam int              NS = 4;
    localparam longint unsigned QS = 17;
    localparam int              NB = 256;
    localparam longint unsigned QB = 8380417;
`ifdef NTT_PWM_EXTRA_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int           addr;
        logic [W-1:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_s, start_s, busy_s, done_s, rd_en_s, wr_en_s;
    logic [1:0]   rd_addr_s, wr_addr_s;
    logic [W-1:0] a_rd_s, b_rd_s, wr_data_s;
    logic [W-1:0] mem_as [NS];
    logic [W-1:0] mem_bs [NS];

    logic         rst_n_b, start_b;
    logic         busy_b [3];
    logic         done_b [3];
    logic         rd_en_b [3];
    logic         wr_en_b [3];
    logic [7:0]   rd_addr_b [3];
    logic [7:0]   wr_addr_b [3];
    logic [W-1:0] a_rd_b [3];
    logic [W-1:0] b_rd_b [3];
    logic [W-1:0] wr_data_b [3];
    logic [W-1:0] mem_ab [NB];
    logic [W-1:0] mem_bb [NB];

    exp_t sq[$];
    exp_t bq[3][$];
    int   wr_cnt_s = 0;
    int   done_cnt_s = 0;
    int   wr_cnt_b [3] = '{0, 0, 0};
    int   done_cnt_b [3] = '{0, 0, 0};

    ntt_pointwise_mult_seq #(.N(NS), .WIDTH(W), .Q(QS), .REDUCTION_TYPE(0)) u_small (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .a_rdata(a_rd_s), .b_rdata(b_rd_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s)
    );

    always @(posedge clk) begin
        if (rd_en_s) begin
            a_rd_s <= mem_as[rd_addr_s];
            b_rd_s <= mem_bs[rd_addr_s];
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_big
        ntt_pointwise_mult_seq #(.N(NB), .WIDTH(W), .Q(QB), .REDUCTION_TYPE(r)) u_dut (
            .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b[r]), .done(done_b[r]),
            .rd_en(rd_en_b[r]), .rd_addr(rd_addr_b[r]), .a_rdata(a_rd_b[r]), .b_rdata(b_rd_b[r]),
            .wr_en(wr_en_b[r]), .wr_addr(wr_addr_b[r]), .wr_data(wr_data_b[r])
        );

        always @(posedge clk) begin
            if (rd_en_b[r]) begin
                a_rd_b[r] <= mem_ab[rd_addr_b[r]];
                b_rd_b[r] <= mem_bb[rd_addr_b[r]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the expected write for every wr_en seen on any instance.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (wr_en_s) begin
            wr_cnt_s++;
            if (sq.size() == 0) begin
                check("small_unexpected_write", {62'd0, wr_addr_s}, 64'hFFFF);
            end else begin
                e = sq.pop_front();
                check("small_wr_addr", {62'd0, wr_addr_s}, 64'(e.addr));
                check("small_wr_data", {32'd0, wr_data_s}, {32'd0, e.data});
            end
        end
        if (done_s) done_cnt_s++;
        for (int r = 0; r < 3; r++) begin
            if (wr_en_b[r]) begin
                wr_cnt_b[r]++;
                if (bq[r].size() == 0) begin
                    check($sformatf("big%0d_unexpected_write", r), {56'd0, wr_addr_b[r]}, 64'hFFFF);
                end else begin
                    e = bq[r].pop_front();
                    check($sformatf("big%0d_wr_addr", r), {56'd0, wr_addr_b[r]}, 64'(e.addr));
                    check($sformatf("big%0d_wr_data", r), {32'd0, wr_data_b[r]}, {32'd0, e.data});
                end
            end
            if (done_b[r]) done_cnt_b[r]++;
        end
    end

    // Edge index k counts posedges after the start-sampling edge E0 (k=0 is cycle c0).
    task automatic run_s(input int restart_at, output int first_wr, output int done_edge, output int busy_cyc);
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s   = 1'b0;
        first_wr  = -1;
        done_edge = -1;
        busy_cyc  = 0;
        for (int k = 0; k < 400 && done_edge < 0; k++) begin
            if (busy_s) busy_cyc++;
            if (wr_en_s && first_wr < 0) first_wr = k;
            if (done_s) done_edge = k;
            start_s = (k == restart_at);
            @(posedge clk);
            #1;
        end
        start_s = 1'b0;
    endtask

    task automatic run_b(output int first_wr, output int done_edge, output int busy_cyc);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b   = 1'b0;
        first_wr  = -1;
        done_edge = -1;
        busy_cyc  = 0;
        for (int k = 0; k < 1000 && done_edge < 0; k++) begin
            if (busy_b[0]) busy_cyc++;
            if (wr_en_b[0] && first_wr < 0) first_wr = k;
            if (done_b[0]) done_edge = k;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_small();
        // Hand-computed mod 17: 1*5=5, 2*6=12, 3*7=21->4, 16*16=256->1.
        sq.push_back('{addr: 0, data: 32'd5});
        sq.push_back('{addr: 1, data: 32'd12});
        sq.push_back('{addr: 2, data: 32'd4});
        sq.push_back('{addr: 3, data: 32'd1});
    endtask

    task automatic small_pass(input string tag, input int restart_at);
        int fw, de, bc, d0, w0;
        d0 = done_cnt_s;
        w0 = wr_cnt_s;
        push_small();
        run_s(restart_at, fw, de, bc);
        check({tag, "_first_wr"}, 64'(fw), 64'(LAT));
        check({tag, "_done_edge"}, 64'(de), 64'(NS + LAT));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(NS + LAT));
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, {63'd0, done_s}, 64'd0);
        check({tag, "_rd_addr_idle"}, {62'd0, rd_addr_s}, 64'd0);
        check({tag, "_wr_addr_idle"}, {62'd0, wr_addr_s}, 64'd0);
        check({tag, "_wr_data_hold"}, {32'd0, wr_data_s}, 64'd1);
        check({tag, "_sb_empty"}, 64'(sq.size()), 64'd0);
        check({tag, "_write_count"}, 64'(wr_cnt_s - w0), 64'(NS));
        check({tag, "_done_count"}, 64'(done_cnt_s - d0), 64'd1);
    endtask

    task automatic big_pass(input string tag);
        int fw, de, bc;
        int d0 [3];
        int w0 [3];
        for (int r = 0; r < 3; r++) begin
            d0[r] = done_cnt_b[r];
            w0[r] = wr_cnt_b[r];
            for (int i = 0; i < NB; i++) begin
                bq[r].push_back('{addr: i, data: W'((64'(mem_ab[i]) * 64'(mem_bb[i])) % QB)});
            end
        end
        run_b(fw, de, bc);
        check({tag, "_first_wr"}, 64'(fw), 64'(LAT));
        check({tag, "_done_edge"}, 64'(de), 64'(NB + LAT));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(NB + LAT));
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            check($sformatf("%s_r%0d_done_single", tag, r), {63'd0, done_b[r]}, 64'd0);
            check($sformatf("%s_r%0d_sb_empty", tag, r), 64'(bq[r].size()), 64'd0);
            check($sformatf("%s_r%0d_write_count", tag, r), 64'(wr_cnt_b[r] - w0[r]), 64'(NB));
            check($sformatf("%s_r%0d_done_count", tag, r), 64'(done_cnt_b[r] - d0[r]), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, d0, w0;
        rst_n_s = 1'b0;
        rst_n_b = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        a_rd_s  = '0;
        b_rd_s  = '0;
        for (int r = 0; r < 3; r++) begin
            a_rd_b[r] = '0;
            b_rd_b[r] = '0;
        end
        mem_as = '{32'd1, 32'd2, 32'd3, 32'd16};
        mem_bs = '{32'd5, 32'd6, 32'd7, 32'd16};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy_s}, 64'd0);
        check("rst_done", {63'd0, done_s}, 64'd0);
        check("rst_rd_en", {63'd0, rd_en_s}, 64'd0);
        check("rst_wr_en", {63'd0, wr_en_s}, 64'd0);
        check("rst_rd_addr", {62'd0, rd_addr_s}, 64'd0);
        check("rst_wr_addr", {62'd0, wr_addr_s}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data_s}, 64'd0);
        @(negedge clk);
        rst_n_s = 1'b1;
        rst_n_b = 1'b1;

        small_pass("s1", -1);
        small_pass("s2_restart", 3);
        small_pass("s3_clean", -1);

        // Asynchronous reset in the cycle that writes C[1].
        push_small();
        d0 = done_cnt_s;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (wr_en_s && wr_addr_s == 2'd1) begin
                found = 1;
                break;
            end
        end
        check("mid_rst_found_wr1", 64'(found), 64'd1);
        rst_n_s = 1'b0;
        #1;
        check("mid_rst_wr_en", {63'd0, wr_en_s}, 64'd0);
        check("mid_rst_rd_en", {63'd0, rd_en_s}, 64'd0);
        check("mid_rst_busy", {63'd0, busy_s}, 64'd0);
        check("mid_rst_done", {63'd0, done_s}, 64'd0);
        sq.delete();
        w0 = wr_cnt_s;
        repeat (4) @(posedge clk);
        #2;
        check("mid_rst_no_writes", 64'(wr_cnt_s - w0), 64'd0);
        check("mid_rst_no_done", 64'(done_cnt_s - d0), 64'd0);
        @(negedge clk);
        rst_n_s = 1'b1;
        small_pass("s4_after_rst", -1);

        // (Q-1)^2 = Q^2 - 2Q + 1 -> 1 for every reduction type.
        for (int i = 0; i < NB; i++) begin
            mem_ab[i] = W'(QB - 1);
            mem_bb[i] = W'(QB - 1);
        end
        big_pass("b_qm1");
        for (int r = 0; r < 3; r++) begin
            check($sformatf("b_qm1_r%0d_last_data", r), {32'd0, wr_data_b[r]}, 64'd1);
        end

        for (int i = 0; i < NB; i++) begin
            mem_ab[i] = '0;
            mem_bb[i] = '0;
        end
        big_pass("b_zero");

        for (int i = 0; i < NB; i++) begin
            mem_ab[i] = $urandom_range(32'(QB - 1), 0);
            mem_bb[i] = $urandom_range(32'(QB - 1), 0);
        end
        mem_ab[0] = W'(QB - 1);
        mem_bb[1] = '0;
        big_pass("b_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
